// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter that shares one six-input, 3-bit select mux
// among six requesters (u, v, w, x, y, z map to requesters 0..5).
// A grant is held for at most HOLD_MAX cycles. Every release is followed by a
// dead cycle (RELEASE) and then a fresh arbitration (IDLE). This gives a minimum
// two-cycle gap between consecutive grants.
//
// Ports:
//   clock    system clock, rising-edge active
//   resetn   asynchronous active-low reset
//   req      level-sensitive request vector, bit i = requester i
//   grant    registered one-hot grant, zero when no grant is active
//   sel      registered mux select (0..5); holds its last value outside GRANT
//   busy     high while a grant is active
//   timeout  one-cycle pulse when a grant is preempted at HOLD_MAX
module mux_rr_arbiter #(
   parameter int unsigned HOLD_MAX  = 15,
   parameter int unsigned LAST_INIT = 5
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic [5:0] req,
   output logic [5:0] grant,
   output logic [2:0] sel,
   output logic       busy,
   output logic       timeout
);

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StGrant   = 2'd1;
   localparam logic [1:0] StRelease = 2'd2;

   logic [1:0] state_q, state_d;
   logic [5:0] grant_q, grant_d;
   logic [2:0] sel_q, sel_d;
   logic       busy_q, busy_d;
   logic       timeout_q, timeout_d;
   logic [2:0] last_q, last_d;
   logic [7:0] hold_cnt_q, hold_cnt_d;

   logic       win_found;
   logic [2:0] win_idx;

   // Scan from the requester after the last owner, wrapping modulo 6. The last
   // owner therefore has the lowest priority.
   always_comb begin
      win_found = 1'b0;
      win_idx   = 3'd0;
      for (int k = 1; k <= 6; k++) begin
         if (!win_found && req[(int'(last_q) + k) % 6]) begin
            win_found = 1'b1;
            win_idx   = 3'((int'(last_q) + k) % 6);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      sel_d      = sel_q;
      busy_d     = busy_q;
      timeout_d  = 1'b0;
      last_d     = last_q;
      hold_cnt_d = hold_cnt_q;
      case (state_q)
         StIdle: begin
            grant_d = 6'b0;
            busy_d  = 1'b0;
            if (win_found) begin
               state_d    = StGrant;
               grant_d    = 6'b1 << win_idx;
               sel_d      = win_idx;
               busy_d     = 1'b1;
               hold_cnt_d = 8'd1;
            end
         end
         StGrant: begin
            // A dropped request takes precedence over expiry, so no timeout is flagged.
            if (!req[sel_q]) begin
               state_d = StRelease;
               grant_d = 6'b0;
               busy_d  = 1'b0;
               last_d  = sel_q;
            end else if (hold_cnt_q == 8'(HOLD_MAX)) begin
               state_d   = StRelease;
               grant_d   = 6'b0;
               busy_d    = 1'b0;
               last_d    = sel_q;
               timeout_d = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_q + 8'd1;
            end
         end
         StRelease: begin
            state_d = StIdle;
            grant_d = 6'b0;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = StIdle;
            grant_d = 6'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q    <= StIdle;
         grant_q    <= 6'b0;
         sel_q      <= 3'd0;
         busy_q     <= 1'b0;
         timeout_q  <= 1'b0;
         last_q     <= 3'(LAST_INIT);
         hold_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         sel_q      <= sel_d;
         busy_q     <= busy_d;
         timeout_q  <= timeout_d;
         last_q     <= last_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   assign grant   = grant_q;
   assign sel     = sel_q;
   assign busy    = busy_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed scenarios and randomized traffic for mux_rr_arbiter.
// Each scenario is checked against explicit constants and against a reference model.
// The model tracks ownership as "who holds the mux, for how long, and who had it last".
module tb_mux_rr_arbiter;

   localparam int HOLD = 15;

   logic       clock;
   logic       resetn;
   logic [5:0] req;
   logic [5:0] grant;
   logic [2:0] sel;
   logic       busy;
   logic       timeout;

   int errors = 0;
   int checks = 0;

   // Reference model.
   // phase: 0 = nobody owns, 1 = owner holds the mux, 2 = dead gap after a release.
   int m_phase;
   int m_owner;
   int m_age;
   int m_prev;
   int m_sel;
   int m_to;

   mux_rr_arbiter #(
      .HOLD_MAX  (HOLD),
      .LAST_INIT (5)
   ) dut (
      .clock   (clock),
      .resetn  (resetn),
      .req     (req),
      .grant   (grant),
      .sel     (sel),
      .busy    (busy),
      .timeout (timeout)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic model_reset();
      m_phase = 0;
      m_owner = 0;
      m_age   = 0;
      m_prev  = 5;
      m_sel   = 0;
      m_to    = 0;
   endtask

   task automatic model_edge(input logic [5:0] r);
      m_to = 0;
      if (m_phase == 0) begin
         for (int k = 1; k <= 6; k++) begin
            if (m_phase == 0 && r[(m_prev + k) % 6]) begin
               m_owner = (m_prev + k) % 6;
               m_sel   = m_owner;
               m_age   = 1;
               m_phase = 1;
            end
         end
      end else if (m_phase == 1) begin
         if (!r[m_owner]) begin
            m_phase = 2;
            m_prev  = m_owner;
         end else if (m_age == HOLD) begin
            m_phase = 2;
            m_prev  = m_owner;
            m_to    = 1;
         end else begin
            m_age++;
         end
      end else begin
         m_phase = 0;
      end
   endtask

   function automatic logic [5:0] m_grant();
      return (m_phase == 1) ? (6'b1 << m_owner) : 6'b0;
   endfunction

   // Advance one clock edge and sample #1 after it.
   task automatic tick();
      @(posedge clock);
      model_edge(req);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clock);
      resetn = 1'b0;
      req    = 6'b0;
      model_reset();
      @(negedge clock);
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (grant !== 6'b0 || sel !== 3'd0 || busy !== 1'b0 || timeout !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: grant=%b sel=%0d busy=%b timeout=%b, required 000000/0/0/0",
                  grant, sel, busy, timeout);
      end
      tick();
      checks++;
      if (grant !== 6'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_no_req: grant=%b busy=%b, required 000000/0", grant, busy);
      end
   endtask

   task automatic test_single_timeout();
      int hi;
      do_reset();
      req = 6'b000001;
      tick();
      checks++;
      if (grant !== 6'b000001 || sel !== 3'd0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_first_grant: grant=%b sel=%0d busy=%b, required 000001/0/1",
                  grant, sel, busy);
      end
      hi = 1;
      for (int i = 0; i < 20 && grant == 6'b000001; i++) begin
         tick();
         if (grant == 6'b000001) hi++;
      end
      checks++;
      if (hi != HOLD || timeout !== 1'b1) begin
         errors++;
         $display("FAIL single_hold: held=%0d timeout=%b, required %0d/1", hi, timeout, HOLD);
      end
      tick();
      checks++;
      if (timeout !== 1'b0 || grant !== 6'b0) begin
         errors++;
         $display("FAIL single_pulse_width: timeout=%b grant=%b, required 0/000000",
                  timeout, grant);
      end
      tick();
      checks++;
      if (grant !== 6'b000001 || sel !== 3'd0) begin
         errors++;
         $display("FAIL single_regrant: grant=%b sel=%0d, required 000001/0", grant, sel);
      end
   endtask

   task automatic test_all_rr();
      int order[$];
      logic prev_busy;
      int  pulses;
      do_reset();
      req       = 6'b111111;
      prev_busy = 1'b0;
      pulses    = 0;
      for (int i = 0; i < 1 + 6 * (HOLD + 2) + 3; i++) begin
         tick();
         if (busy && !prev_busy) order.push_back(int'(sel));
         if (timeout) pulses++;
         prev_busy = busy;
         checks++;
         if (grant !== m_grant() || sel !== 3'(m_sel) || timeout !== 1'(m_to)) begin
            errors++;
            $display("FAIL rr_model cyc %0d: grant=%b sel=%0d to=%b, required %b/%0d/%0d",
                     i, grant, sel, timeout, m_grant(), m_sel, m_to);
         end
      end
      checks++;
      if (order.size() != 7 || pulses != 6) begin
         errors++;
         $display("FAIL rr_count: grants=%0d pulses=%0d, required 7/6", order.size(), pulses);
      end else begin
         for (int i = 0; i < 7; i++) begin
            checks++;
            if (order[i] != i % 6) begin
               errors++;
               $display("FAIL rr_order[%0d]: sel=%0d, required %0d", i, order[i], i % 6);
            end
         end
      end
   endtask

   task automatic test_early_drop();
      do_reset();
      req = 6'b000100;
      tick();
      req = 6'b010110;
      tick();
      tick();
      tick();
      checks++;
      if (grant !== 6'b000100 || sel !== 3'd2) begin
         errors++;
         $display("FAIL drop_holds_owner: grant=%b sel=%0d, required 000100/2", grant, sel);
      end
      req = 6'b010010;
      tick();
      checks++;
      if (grant !== 6'b0 || busy !== 1'b0 || timeout !== 1'b0 || sel !== 3'd2) begin
         errors++;
         $display("FAIL drop_release: grant=%b busy=%b to=%b sel=%0d, required 000000/0/0/2",
                  grant, busy, timeout, sel);
      end
      tick();
      tick();
      checks++;
      if (grant !== 6'b010000 || sel !== 3'd4) begin
         errors++;
         $display("FAIL drop_next_winner: grant=%b sel=%0d, required 010000/4", grant, sel);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      req = 6'b100000;
      tick();
      checks++;
      if (sel !== 3'd5 || grant !== 6'b100000) begin
         errors++;
         $display("FAIL wrap_grant5: grant=%b sel=%0d, required 100000/5", grant, sel);
      end
      req = 6'b001001;
      tick();
      tick();
      tick();
      checks++;
      if (sel !== 3'd0 || grant !== 6'b000001) begin
         errors++;
         $display("FAIL wrap_next: grant=%b sel=%0d, required 000001/0", grant, sel);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      req = 6'b000100;
      tick();
      tick();
      #2;
      resetn = 1'b0;
      #1;
      checks++;
      if (grant !== 6'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: grant=%b busy=%b, required 000000/0", grant, busy);
      end
      model_reset();
      req = 6'b100001;
      @(negedge clock);
      resetn = 1'b1;
      tick();
      checks++;
      if (grant !== 6'b000001 || sel !== 3'd0) begin
         errors++;
         $display("FAIL async_rearb: grant=%b sel=%0d, required 000001/0", grant, sel);
      end
   endtask

   task automatic test_drop_at_max();
      do_reset();
      req = 6'b000001;
      for (int i = 0; i < HOLD; i++) tick();
      checks++;
      if (grant !== 6'b000001) begin
         errors++;
         $display("FAIL max_still_held: grant=%b, required 000001", grant);
      end
      req = 6'b0;
      tick();
      checks++;
      if (grant !== 6'b0 || timeout !== 1'b0) begin
         errors++;
         $display("FAIL max_drop_no_timeout: grant=%b to=%b, required 000000/0", grant, timeout);
      end
   endtask

   task automatic test_random();
      logic prev_to;
      do_reset();
      prev_to = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) < 3) req = 6'($urandom);
         tick();
         checks++;
         if (grant !== m_grant() || sel !== 3'(m_sel) || busy !== 1'(m_phase == 1) ||
             timeout !== 1'(m_to)) begin
            errors++;
            $display("FAIL rand_model cyc %0d: g=%b s=%0d b=%b t=%b, required %b/%0d/%0d/%0d",
                     i, grant, sel, busy, timeout, m_grant(), m_sel, m_phase == 1, m_to);
         end
         checks++;
         if ((grant & (grant - 6'd1)) != 6'b0 || sel > 3'd5 || (prev_to && timeout)) begin
            errors++;
            $display("FAIL rand_invariant cyc %0d: grant=%b sel=%0d timeout=%b prev=%b",
                     i, grant, sel, timeout, prev_to);
         end
         prev_to = timeout;
      end
   endtask

   initial begin
      resetn = 1'b0;
      req    = 6'b0;
      model_reset();
      test_reset();
      test_single_timeout();
      test_all_rr();
      test_early_drop();
      test_wrap();
      test_async_reset();
      test_drop_at_max();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
